fft_stage_sequencer: RTL

- Parametrised multi-stage controller for the in-place radix-2 FFT datapath with four memory banks.
- On a start pulse it steps through all LOG2N stages by itself. For each stage it issues read addresses, then write addresses delayed by the butterfly pipeline latency, plus twiddle addresses.
- It waits for each stage's writes to drain before the next stage reads, which removes the read-after-write hazard.
- Supports a stall input, a per-stage done pulse and a start/busy/done handshake. It sits between the top-level FFT control and the bank RAMs/butterfly.

---
 rtl/fft_stage_sequencer.sv | 125 ++++++++++++
 1 files changed

// File: rtl/fft_stage_sequencer.sv
// Stage sequencer for an in-place radix-2 FFT over four banks: reads each stage,
// issues the matching writes PIPE_LAT cycles later, and drains before the next stage reads.
module fft_stage_sequencer #(
  parameter int LOG2N    = 5,
  parameter int PIPE_LAT = 2,
  localparam int Q  = 2 ** (LOG2N - 2),
  localparam int AW = LOG2N - 2,
  localparam int SW = $clog2(LOG2N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          hold,
  output logic          busy,
  output logic          done,
  output logic [SW-1:0] stage,
  output logic          stage_done,
  output logic          rd_valid,
  output logic [AW-1:0] rd_addr,
  output logic [AW-1:0] tw_addr,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [1:0]    state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  localparam logic [AW-1:0] K_LAST     = '1;
  localparam logic [SW-1:0] LAST_STAGE = SW'(LOG2N - 1);

  state_t        r_state, w_next_state;
  logic [AW-1:0] r_k, w_next_k;
  logic [SW-1:0] r_stage, w_next_stage;
  logic          r_done, w_next_done;

  // Delay line: valid, last-of-stage tag and address of each read, oldest at index PIPE_LAT-1.
  logic [PIPE_LAT-1:0]         r_dl_v;
  logic [PIPE_LAT-1:0]         r_dl_last;
  logic [PIPE_LAT-1:0][AW-1:0] r_dl_a;

  logic w_rd_active;
  logic w_k_last;
  logic w_wr_last;

  assign w_rd_active = (r_state == S_READ);
  assign w_k_last    = (r_k == K_LAST);
  assign w_wr_last   = r_dl_v[PIPE_LAT-1] & r_dl_last[PIPE_LAT-1];

  always_comb begin
    w_next_state = r_state;
    w_next_k     = r_k;
    w_next_stage = r_stage;
    w_next_done  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next_state = S_READ;
          w_next_k     = '0;
          w_next_stage = '0;
        end
      end
      S_READ: begin
        if (w_k_last) w_next_state = S_DRAIN;
        else          w_next_k     = r_k + AW'(1);
      end
      S_DRAIN: begin
        // k only wraps here, once the stage's last write is on the bus.
        if (w_wr_last) begin
          w_next_k = '0;
          if (r_stage == LAST_STAGE) begin
            w_next_state = S_IDLE;
            w_next_stage = '0;
            w_next_done  = 1'b1;
          end else begin
            w_next_state = S_READ;
            w_next_stage = r_stage + SW'(1);
          end
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // hold freezes every register, including the pending done pulse and the delay line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_k       <= '0;
      r_stage   <= '0;
      r_done    <= 1'b0;
      r_dl_v    <= '0;
      r_dl_last <= '0;
      r_dl_a    <= '0;
    end else if (!hold) begin
      r_state      <= w_next_state;
      r_k          <= w_next_k;
      r_stage      <= w_next_stage;
      r_done       <= w_next_done;
      r_dl_v[0]    <= w_rd_active;
      r_dl_last[0] <= w_rd_active & w_k_last;
      r_dl_a[0]    <= r_k;
      for (int i = 1; i < PIPE_LAT; i++) begin
        r_dl_v[i]    <= r_dl_v[i-1];
        r_dl_last[i] <= r_dl_last[i-1];
        r_dl_a[i]    <= r_dl_a[i-1];
      end
    end
  end

  assign busy       = (r_state != S_IDLE);
  assign done       = r_done & ~hold;
  assign stage      = r_stage;
  assign stage_done = w_wr_last & ~hold;
  assign rd_valid   = w_rd_active & ~hold;
  assign rd_addr    = r_k;
  assign tw_addr    = r_k << r_stage;
  assign wr_en      = r_dl_v[PIPE_LAT-1] & ~hold;
  assign wr_addr    = r_dl_a[PIPE_LAT-1];
  assign state_dbg  = r_state;

endmodule
